// File: rtl/apb_mon_pkg.sv
// ---------------------------------------------------------------------------
// apb_mon_pkg
//   Shared types and constants for the APB protocol monitor.
//   - phase_e : registered bus phase (IDLE, SETUP, WAIT, LAST)
//   - ERR_*   : bit positions inside the sticky error vector
//   - ERR_W   : width of the error vector
// ---------------------------------------------------------------------------
package apb_mon_pkg;

  // WAIT and LAST both belong to the ACCESS phase. They differ only in PREADY.
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_WAIT  = 2'd2,
    PH_LAST  = 2'd3
  } phase_e;

  localparam int ERR_W       = 5;
  localparam int ERR_ONEHOT  = 0;
  localparam int ERR_SEQ     = 1;
  localparam int ERR_STABLE  = 2;
  localparam int ERR_STRB    = 3;
  localparam int ERR_TIMEOUT = 4;

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// ---------------------------------------------------------------------------
// apb_mon_sat_cnt
//   Saturating event counter with a synchronous clear.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear. A coinciding inc still counts, so the
//                  result is 1.
//     inc        : count one event; holds at all-ones once saturated
//     cnt        : current count
// ---------------------------------------------------------------------------
module apb_mon_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= WIDTH'(inc);
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_monitor.sv
// ---------------------------------------------------------------------------
// apb_protocol_monitor
//   Passive observer of one APB segment (one requester, NUM_SEL completers).
//   It classifies every cycle, checks the classification against the
//   previous cycle's phase and bus snapshot, and reports violations as sticky
//   flags. It also keeps saturating transfer statistics.
//   Ports:
//     PCLK, PRESETn       : bus clock, asynchronous active-low reset
//     PADDR..PSLVERR      : observed APB signals (inputs only)
//     clr_i               : synchronous clear of flags, capture and counters
//     err_o               : sticky flags {TIMEOUT, STRB, STABLE, SEQ, ONEHOT}
//     irq_o               : OR of err_o
//     err_valid_o         : err_addr_o holds a captured address
//     err_addr_o          : PADDR of the first violating cycle
//     wr_cnt_o, rd_cnt_o  : completed writes / reads
//     slverr_cnt_o        : completions with PSLVERR=1
// ---------------------------------------------------------------------------
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [2:0]              PPROT,
  input  logic [NUM_SEL-1:0]      PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic                    PREADY,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PSLVERR,
  input  logic                    clr_i,
  output logic [ERR_W-1:0]        err_o,
  output logic                    irq_o,
  output logic                    err_valid_o,
  output logic [ADDR_WIDTH-1:0]   err_addr_o,
  output logic [CNT_WIDTH-1:0]    wr_cnt_o,
  output logic [CNT_WIDTH-1:0]    rd_cnt_o,
  output logic [CNT_WIDTH-1:0]    slverr_cnt_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // The wait counter only needs to reach TIMEOUT. Saturation keeps it at or
  // above TIMEOUT, so the timeout compare can match at most once per stall.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_FIRE = WAIT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  // Read data is observed but no check depends on it.
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;

  // ------------------------------------------------------------------
  // Classification of the current cycle
  // ------------------------------------------------------------------
  phase_e cur_phase;
  phase_e state_q;
  logic   access;
  logic   complete;

  always_comb begin
    // NOTE: assign every always_comb output a default before branching.
    // A path that leaves it unassigned would infer a latch.
    cur_phase = PH_IDLE;
    if (PSEL != '0) begin
      if (!PENABLE)    cur_phase = PH_SETUP;
      else if (PREADY) cur_phase = PH_LAST;
      else             cur_phase = PH_WAIT;
    end
  end

  assign access   = (cur_phase == PH_WAIT) || (cur_phase == PH_LAST);
  assign complete = (cur_phase == PH_LAST);

  // ------------------------------------------------------------------
  // Previous-cycle phase and bus snapshot. The FSM always follows the bus,
  // so one bad cycle cannot leave it stuck.
  // ------------------------------------------------------------------
  logic [NUM_SEL-1:0]    psel_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [2:0]            pprot_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [WAIT_W-1:0]     wait_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then sees pre-edge values, whatever the statement order.
    if (!PRESETn) begin
      state_q  <= PH_IDLE;
      psel_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pprot_q  <= '0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= cur_phase;
      psel_q   <= PSEL;
      paddr_q  <= PADDR;
      pwrite_q <= PWRITE;
      pprot_q  <= PPROT;
      pstrb_q  <= PSTRB;
      pwdata_q <= PWDATA;
      if (!access)                     wait_q <= '0;
      else if (!PREADY && !(&wait_q))  wait_q <= wait_q + WAIT_W'(1);
    end
  end

  // ------------------------------------------------------------------
  // Protocol checks
  // ------------------------------------------------------------------
  logic             from_idle_last;
  logic             ctrl_changed;
  logic [ERR_W-1:0] err_vec;
  logic [ERR_W-1:0] err_next;

  assign from_idle_last = (state_q == PH_IDLE) || (state_q == PH_LAST);
  assign ctrl_changed   = (PADDR != paddr_q) || (PWRITE != pwrite_q) ||
                          (PPROT != pprot_q) || (PSTRB != pstrb_q)   ||
                          (PWRITE && (PWDATA != pwdata_q));

  always_comb begin
    err_vec              = '0;
    err_vec[ERR_ONEHOT]  = $countones(PSEL) > 1;
    err_vec[ERR_SEQ]     = from_idle_last ? access
                                          : (!access || (PSEL != psel_q));
    err_vec[ERR_STABLE]  = !from_idle_last && access && ctrl_changed;
    err_vec[ERR_STRB]    = (PSEL != '0) && !PWRITE && (PSTRB != '0);
    // Matching one below the limit means this wait cycle is the TIMEOUT-th one.
    err_vec[ERR_TIMEOUT] = (TIMEOUT != 0) && access && !PREADY &&
                           (wait_q == WAIT_FIRE);
  end

  // The clear takes effect first, so a violation in the same cycle survives it.
  assign err_next = clr_i ? err_vec : (err_o | err_vec);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_o       <= '0;
      irq_o       <= 1'b0;
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else begin
      err_o <= err_next;
      irq_o <= |err_next;
      if (clr_i) begin
        err_valid_o <= |err_vec;
        err_addr_o  <= (|err_vec) ? PADDR : '0;
      end else if ((|err_vec) && !err_valid_o) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= PADDR;
      end
    end
  end

  // ------------------------------------------------------------------
  // Transfer statistics
  // ------------------------------------------------------------------
  apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_wr_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clr_i),
    .inc   (complete && PWRITE),
    .cnt   (wr_cnt_o)
  );

  apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_rd_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clr_i),
    .inc   (complete && !PWRITE),
    .cnt   (rd_cnt_o)
  );

  apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_slverr_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clr_i),
    .inc   (complete && PSLVERR),
    .cnt   (slverr_cnt_o)
  );

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// ---------------------------------------------------------------------------
// tb_apb_protocol_monitor
//   Directed bus sequences drive both monitors. The main monitor has
//   TIMEOUT=4 and the second has TIMEOUT=0. The stimulus queues hand-computed
//   expected outputs, and a separate monitor process compares them 1 time
//   unit after the clock edge, or right after reset falls.
// ---------------------------------------------------------------------------
module tb_apb_protocol_monitor;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        clr;

  logic [4:0]  err, err0;
  logic        irq, irq0;
  logic        err_valid, err_valid0;
  logic [31:0] err_addr, err_addr0;
  logic [15:0] wr_cnt, rd_cnt, slverr_cnt;
  logic [15:0] wr_cnt0, rd_cnt0, slverr_cnt0;

  always #5 pclk = ~pclk;

  apb_protocol_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4), .TIMEOUT(4), .CNT_WIDTH(16)
  ) dut (
    .PCLK(pclk), .PRESETn(presetn), .PADDR(paddr), .PPROT(pprot), .PSEL(psel),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr), .clr_i(clr),
    .err_o(err), .irq_o(irq), .err_valid_o(err_valid), .err_addr_o(err_addr),
    .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt), .slverr_cnt_o(slverr_cnt)
  );

  apb_protocol_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(4), .TIMEOUT(0), .CNT_WIDTH(16)
  ) dut_no_to (
    .PCLK(pclk), .PRESETn(presetn), .PADDR(paddr), .PPROT(pprot), .PSEL(psel),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr), .clr_i(clr),
    .err_o(err0), .irq_o(irq0), .err_valid_o(err_valid0), .err_addr_o(err_addr0),
    .wr_cnt_o(wr_cnt0), .rd_cnt_o(rd_cnt0), .slverr_cnt_o(slverr_cnt0)
  );

  typedef struct {
    string       name;
    int          at;
    logic [4:0]  err;
    logic        valid;
    logic [31:0] addr;
    logic [15:0] wr;
    logic [15:0] rd;
    logic [15:0] slv;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   passed   = 0;
  int   total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Queue an expectation for the outputs registered `delay` edges from now.
  // A delay of 0 is picked up at the next reset fall.
  task automatic expect_out(input string name, input logic [4:0] e, input logic v,
                            input logic [31:0] a, input int w, input int r,
                            input int s, input int delay = 1);
    exp_t x;
    x.name = name; x.at = edge_cnt + delay; x.err = e; x.valid = v; x.addr = a;
    x.wr = 16'(w); x.rd = 16'(r); x.slv = 16'(s);
    q.push_back(x);
  endtask

  // Present one bus cycle, then move to the next falling edge.
  task automatic drive(input logic [3:0] sel, input logic en, input logic [31:0] addr,
                       input logic wr, input logic [31:0] wd, input logic [3:0] strb,
                       input logic rdy, input logic serr, input logic c);
    psel = sel; penable = en; paddr = addr; pwrite = wr; pwdata = wd;
    pstrb = strb; pready = rdy; pslverr = serr; clr = c;
    @(negedge pclk);
  endtask

  task automatic idle(input logic c = 1'b0);
    drive(4'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, c);
  endtask

  // Monitor: wakes on each rising clock (or a reset fall) and checks every
  // expectation that has come due.
  initial begin
    exp_t e;
    forever begin
      @(posedge pclk or negedge presetn);
      if (pclk) edge_cnt++;
      #1;
      while (q.size() > 0 && q[0].at <= edge_cnt) begin
        e = q.pop_front();
        check({e.name, ".err"},   32'(err),        32'(e.err));
        check({e.name, ".irq"},   32'(irq),        32'(|e.err));
        check({e.name, ".valid"}, 32'(err_valid),  32'(e.valid));
        check({e.name, ".addr"},  err_addr,        e.addr);
        check({e.name, ".wr"},    32'(wr_cnt),     32'(e.wr));
        check({e.name, ".rd"},    32'(rd_cnt),     32'(e.rd));
        check({e.name, ".slv"},   32'(slverr_cnt), 32'(e.slv));
        check({e.name, ".err_no_timeout"}, 32'(err0), 32'(e.err & 5'b01111));
      end
    end
  end

  initial begin
    presetn = 1'b0; pprot = 3'b010; prdata = 32'h0;
    psel = '0; penable = 0; paddr = '0; pwrite = 0; pwdata = '0;
    pstrb = '0; pready = 0; pslverr = 0; clr = 0;
    expect_out("reset", 5'b0, 0, 32'h0, 0, 0, 0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    idle();

    // Legal write with two wait states, then a back-to-back read with PSLVERR.
    drive(4'b0001, 0, 32'h100, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    drive(4'b0001, 1, 32'h100, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    expect_out("wr_wait2", 5'b0, 0, 32'h0, 0, 0, 0);
    drive(4'b0001, 1, 32'h100, 1, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    expect_out("wr_done", 5'b0, 0, 32'h0, 1, 0, 0);
    drive(4'b0001, 1, 32'h100, 1, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    drive(4'b0001, 0, 32'h200, 0, 32'h0, 4'h0, 0, 0, 0);
    expect_out("rd_slverr", 5'b0, 0, 32'h0, 1, 1, 1);
    drive(4'b0001, 1, 32'h200, 0, 32'h0, 4'h0, 1, 1, 0);
    idle();

    // Address changes from SETUP to ACCESS, then a SEQ violation keeps the address.
    drive(4'b0001, 0, 32'h100, 1, 32'hCAFE0001, 4'hF, 0, 0, 0);
    expect_out("stable", 5'b00100, 1, 32'h104, 2, 1, 1);
    drive(4'b0001, 1, 32'h104, 1, 32'hCAFE0001, 4'hF, 1, 0, 0);
    idle();
    expect_out("seq_keep_addr", 5'b00110, 1, 32'h104, 2, 2, 1);
    drive(4'b0001, 1, 32'h300, 0, 32'h0, 4'h0, 1, 0, 0);
    idle();
    expect_out("clr_all", 5'b0, 0, 32'h0, 0, 0, 0);
    idle(1'b1);

    // Two selects active, then a read with nonzero strobes.
    expect_out("onehot", 5'b00001, 1, 32'h40, 0, 0, 0);
    drive(4'b0011, 0, 32'h40, 0, 32'h0, 4'h0, 0, 0, 0);
    expect_out("onehot_done", 5'b00001, 1, 32'h40, 0, 1, 0);
    drive(4'b0011, 1, 32'h40, 0, 32'h0, 4'h0, 1, 0, 0);
    idle();
    expect_out("strb_read", 5'b01001, 1, 32'h40, 0, 1, 0);
    drive(4'b0001, 0, 32'h44, 0, 32'h0, 4'h1, 0, 0, 0);
    expect_out("strb_done", 5'b01001, 1, 32'h40, 0, 2, 0);
    drive(4'b0001, 1, 32'h44, 0, 32'h0, 4'h1, 1, 0, 0);
    idle();
    expect_out("clr2", 5'b0, 0, 32'h0, 0, 0, 0);
    idle(1'b1);

    // Six wait states against TIMEOUT=4. The clear on wait 5 must not re-arm the flag.
    drive(4'b0010, 0, 32'h500, 1, 32'h1, 4'h3, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k < 4)       expect_out($sformatf("to_wait%0d", k), 5'b0, 0, 32'h0, 0, 0, 0);
      else if (k == 4) expect_out("to_fire", 5'b10000, 1, 32'h500, 0, 0, 0);
      else             expect_out($sformatf("to_once%0d", k), 5'b0, 0, 32'h0, 0, 0, 0);
      drive(4'b0010, 1, 32'h500, 1, 32'h1, 4'h3, 0, 0, (k == 5));
    end
    expect_out("to_done", 5'b0, 0, 32'h0, 1, 0, 0);
    drive(4'b0010, 1, 32'h500, 1, 32'h1, 4'h3, 1, 0, 0);
    idle();

    // PENABLE straight from IDLE; clear; clear coinciding with completion / violation.
    expect_out("seq_from_idle", 5'b00010, 1, 32'h600, 1, 1, 0);
    drive(4'b0001, 1, 32'h600, 0, 32'h0, 4'h0, 1, 0, 0);
    idle();
    expect_out("clr3", 5'b0, 0, 32'h0, 0, 0, 0);
    idle(1'b1);
    drive(4'b0001, 0, 32'h700, 1, 32'h11, 4'hF, 0, 0, 0);
    expect_out("wr_before_clr", 5'b0, 0, 32'h0, 1, 0, 0);
    drive(4'b0001, 1, 32'h700, 1, 32'h11, 4'hF, 1, 0, 0);
    idle();
    drive(4'b0001, 0, 32'h704, 1, 32'h22, 4'hF, 0, 0, 0);
    expect_out("clr_with_done", 5'b0, 0, 32'h0, 1, 0, 0);
    drive(4'b0001, 1, 32'h704, 1, 32'h22, 4'hF, 1, 0, 1);
    idle();
    expect_out("clr_with_viol", 5'b00001, 1, 32'h800, 0, 0, 0);
    drive(4'b0011, 0, 32'h800, 0, 32'h0, 4'h0, 0, 0, 1);
    expect_out("viol_done", 5'b00001, 1, 32'h800, 0, 1, 0);
    drive(4'b0011, 1, 32'h800, 0, 32'h0, 4'h0, 1, 0, 0);
    idle();

    // Seven back-to-back writes, then reset during a wait state.
    expect_out("clr4", 5'b0, 0, 32'h0, 0, 0, 0);
    idle(1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(4'b0100, 0, 32'h900 + 32'(i * 4), 1, 32'(i), 4'hF, 0, 0, 0);
      if (i == 6) expect_out("seven_writes", 5'b0, 0, 32'h0, 7, 0, 0);
      drive(4'b0100, 1, 32'h900 + 32'(i * 4), 1, 32'(i), 4'hF, 1, 0, 0);
    end
    drive(4'b0001, 0, 32'hA00, 1, 32'h5, 4'hF, 0, 0, 0);
    drive(4'b0001, 1, 32'hA00, 1, 32'h5, 4'hF, 0, 0, 0);
    #2;
    expect_out("reset_in_wait", 5'b0, 0, 32'h0, 0, 0, 0, 0);
    presetn = 1'b0;
    @(negedge pclk);
    expect_out("seq_after_reset", 5'b00010, 1, 32'hA00, 0, 0, 0);
    presetn = 1'b1;
    @(negedge pclk);
    expect_out("after_reset_done", 5'b00010, 1, 32'hA00, 1, 0, 0);
    drive(4'b0001, 1, 32'hA00, 1, 32'h5, 4'hF, 1, 0, 0);
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge pclk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations still pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_protocol_monitor.md
# apb_protocol_monitor

Synthesizable APB protocol monitor that sits passively on an APB bus segment between one requester and up to NUM_SEL completers. It tracks the transfer phase cycle by cycle and flags protocol violations as sticky error bits, including PREADY wait-state timeouts. It keeps saturating transfer statistics and captures the address of the first violation. The results are usable in silicon (interrupt/status) as well as in simulation.

## Interface

Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8; PSTRB is DATA_WIDTH/8
- NUM_SEL, 4, number of PSEL lines (completers), 1..16
- TIMEOUT, 16, wait-cycle limit before TIMEOUT error; 0 disables the check
- CNT_WIDTH, 16, width of statistics counters

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PADDR  in  ADDR_WIDTH  observed address
- PPROT  in  3  observed protection
- PSEL  in  NUM_SEL  observed selects
- PENABLE  in  1  observed enable
- PWRITE  in  1  observed direction
- PWDATA  in  DATA_WIDTH  observed write data
- PSTRB  in  DATA_WIDTH/8  observed strobes
- PREADY  in  1  observed ready of selected completer
- PRDATA  in  DATA_WIDTH  observed read data (unused by checks, kept for completeness)
- PSLVERR  in  1  observed error response
- clr_i  in  1  synchronous clear of err_o, err_addr_o, err_valid_o and all counters
- err_o  out  5  sticky violation flags: [0] ONEHOT, [1] SEQ, [2] STABLE, [3] STRB, [4] TIMEOUT
- irq_o  out  1  OR of err_o
- err_valid_o  out  1  err_addr_o holds a captured address
- err_addr_o  out  ADDR_WIDTH  PADDR of the first violating cycle since reset/clear
- wr_cnt_o, rd_cnt_o, slverr_cnt_o  out  CNT_WIDTH each  completed writes, completed reads, completions with PSLVERR=1

## Operation

- Current-cycle phase: IDLE if PSEL==0; SETUP if PSEL!=0 and !PENABLE; ACCESS otherwise.
- FSM (registered previous-cycle phase) states:
  - IDLE
  - SETUP
  - WAIT: ACCESS with PREADY=0
  - LAST: ACCESS with PREADY=1
- Next state is always the current cycle's classification, regardless of errors. The FSM never stalls; it resynchronises to the bus.
- Snapshot registers hold the previous cycle's PSEL, PADDR, PWRITE, PPROT, PSTRB and PWDATA.
- Checks, evaluated every cycle:
  - ONEHOT: more than one PSEL bit set.
  - SEQ, from IDLE or LAST: current phase is ACCESS.
  - SEQ, from SETUP or WAIT: current phase is not ACCESS, or PSEL differs from the snapshot.
  - STABLE, from SETUP or WAIT with current phase ACCESS: PADDR, PWRITE, PPROT or PSTRB differs from the snapshot; or PWRITE=1 and PWDATA differs.
  - STRB: PSEL!=0, PWRITE=0 and PSTRB!=0.
  - TIMEOUT: the wait counter reaches TIMEOUT while PREADY=0. Flagged at most once per transfer.
- Wait counter:
  - Cleared on any non-ACCESS cycle.
  - Increments (saturating) on each ACCESS cycle with PREADY=0.
  - TIMEOUT fires on the TIMEOUT-th consecutive such cycle.
- Completion is an ACCESS cycle with PREADY=1:
  - Increments wr_cnt_o if PWRITE=1, otherwise rd_cnt_o.
  - Additionally increments slverr_cnt_o if PSLVERR=1.
  - All counters saturate at all-ones.
- Error capture: on any violation while err_valid_o=0, load err_addr_o with the current PADDR and set err_valid_o.
- clr_i in the same cycle as a violation or completion: the clear applies first, then the event. Result is flag set, counter = 1, address captured.

## Timing

- Every output is registered; a violation or completion seen in cycle N is visible after the PCLK edge ending cycle N (latency 1).
- Reset values:
  - err_o = 0, irq_o = 0, err_valid_o = 0, err_addr_o = 0
  - all counters = 0
  - FSM = IDLE, wait counter = 0, snapshots = 0
- Reset asserted mid-transfer clears everything immediately. After release, the first cycle is judged from IDLE, so a bus still in ACCESS raises SEQ.
- Back-to-back transfers (LAST followed directly by SETUP) are legal with zero idle cycles.
- Multiple violations in one cycle set all corresponding bits; err_addr_o is captured once.

## Structure

- Package apb_mon_pkg:
  - phase enum (IDLE, SETUP, WAIT, LAST)
  - error bit index localparams (ERR_ONEHOT=0 … ERR_TIMEOUT=4)
  - ERR_W=5
- Sub-module apb_mon_sat_cnt: parameter WIDTH; inputs clr and inc; saturating output. Instantiated three times for the counters.
- Everything else (FSM, snapshots, wait counter, checks, error capture) lives in apb_protocol_monitor.

## Test plan

- Legal write to 0x100 (PSEL=4'b0001, PSTRB=4'hF), two wait cycles, then read with PSLVERR=1 -> err_o=0, wr_cnt_o=1, rd_cnt_o=1, slverr_cnt_o=1.
- PADDR changes 0x100->0x104 between SETUP and ACCESS -> err_o[2]=1 next cycle, err_addr_o=0x104, irq_o=1. A later SEQ error leaves err_addr_o at 0x104.
- PSEL=4'b0011 for one cycle -> err_o[0]=1. A read with PSTRB=4'h1 -> err_o[3]=1.
- TIMEOUT=4, PREADY held low for 6 ACCESS cycles -> err_o[4] sets after the 4th wait cycle, exactly once. TIMEOUT=0 run -> no error.
- PENABLE=1 straight from IDLE -> err_o[1]=1. clr_i pulsed -> all outputs 0. clr_i coincident with a completion -> counter = 1.
- PRESETn asserted during WAIT with counters at 7 -> all outputs 0 immediately. Release with bus still in ACCESS -> err_o[1]=1.
